cp0_exc_regs: RTL and testbench

//  Parametrised CP0 register file with precise-exception support for the OpenMIPS core.

---
 rtl/cp0_exc_regs_pkg.sv | 38 +++
 rtl/cp0_exc_regs_if.sv | 36 +++
 rtl/cp0_exc_regs_timer.sv | 67 ++++++
 rtl/cp0_exc_regs.sv | 134 +++++++++++++
 tb/tb_cp0_exc_regs.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exc_regs_pkg.sv
// Shared CP0 register numbers, exception codes and bit positions.
// Also holds the per-cycle commit type that sets field update priority.
package cp0_exc_regs_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_PRID     = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    localparam logic [31:0] STATUS_RST    = 32'h1000_0000;
    localparam logic [3:0]  STATUS_CU     = 4'b0001;
    // Software-writable Cause bits: IP[9:8] and [23:22]
    localparam logic [31:0] CAUSE_SW_MASK = 32'h00C0_0300;

    // Highest-priority event that owns Status/Cause/EPC this cycle
    typedef enum logic [1:0] {
        CMT_NONE = 2'd0,
        CMT_MTC0 = 2'd1,
        CMT_ERET = 2'd2,
        CMT_EXC  = 2'd3
    } commit_e;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_exc_regs_if.sv
// Pipeline-facing CP0 bus: MTC0/MFC0 access, exception/ERET commit and live outputs.
// Strobes (we_i, exc_valid_i, eret_i) are single-cycle, sampled on posedge; no ready, CP0 always accepts.
interface cp0_exc_regs_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  we_i;
    logic [4:0]            waddr_i;
    logic [4:0]            raddr_i;
    logic [31:0]           data_i;
    logic [NUM_HW_INT-1:0] int_i;
    logic                  exc_valid_i;
    logic [4:0]            exc_code_i;
    logic [31:0]           exc_pc_i;
    logic                  exc_in_delay_i;
    logic [31:0]           exc_badva_i;
    logic                  eret_i;
    logic [31:0]           data_o;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;
    logic                  int_pending_o;
    logic                  timer_int_o;

    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_in_delay_i, exc_badva_i, eret_i,
        input  data_o, status_o, cause_o, epc_o, int_pending_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_in_delay_i, exc_badva_i, eret_i,
        output data_o, status_o, cause_o, epc_o, int_pending_o, timer_int_o
    );

endinterface

// File: rtl/cp0_exc_regs_timer.sv
// CP0 Count/Compare timer with optional divide-by-2 prescale and sticky match flag.
// A Compare write clears the flag and beats a simultaneous match.
module cp0_timer
    import cp0_exc_regs_pkg::*;
#(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q, phase_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        count_d     = count_q;
        phase_d     = phase_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;

        if (count_we_i) begin
            count_d = wdata_i;
            phase_d = 1'b0;
        end else if (COUNT_DIV == 1) begin
            count_d = count_q + 32'd1;
        end else begin
            phase_d = ~phase_q;
            if (phase_q) begin
                count_d = count_q + 32'd1;
            end
        end

        if (compare_we_i) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 32'd0;
            phase_q     <= 1'b0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            phase_q     <= phase_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_exc_regs.sv
// CP0 register file with precise exceptions: Status/Cause/EPC/BadVAddr, interrupt gating, timer.
// Per-field priority each cycle is exception > ERET > MTC0; Count/Compare writes are never dropped.
module cp0_exc_regs
    import cp0_exc_regs_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input logic           clk,
    input logic           rst,
    cp0_exc_regs_if.slave bus
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        timer_int;
    logic        count_we, compare_we;
    commit_e     commit;
    logic [5:0]  hw_ip;
    logic [31:0] rdata;

    assign count_we   = bus.we_i && (bus.waddr_i == CP0_REG_COUNT);
    assign compare_we = bus.we_i && (bus.waddr_i == CP0_REG_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (bus.data_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );

    always_comb begin
        if (bus.exc_valid_i) begin
            commit = CMT_EXC;
        end else if (bus.eret_i) begin
            commit = CMT_ERET;
        end else if (bus.we_i) begin
            commit = CMT_MTC0;
        end else begin
            commit = CMT_NONE;
        end
    end

    // IP7 is shared between the timer and the sixth hardware line when it exists
    always_comb begin
        hw_ip                   = 6'd0;
        hw_ip[NUM_HW_INT-1:0]   = bus.int_i;
        hw_ip[5]                = hw_ip[5] | timer_int;
    end

    always_comb begin
        status_d       = status_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        badvaddr_d     = badvaddr_q;
        cause_d[15:10] = hw_ip;

        case (commit)
            CMT_EXC: begin
                cause_d[6:2] = bus.exc_code_i;
                if (!status_q[STATUS_EXL]) begin
                    epc_d             = bus.exc_in_delay_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                    cause_d[CAUSE_BD] = bus.exc_in_delay_i;
                end
                status_d[STATUS_EXL] = 1'b1;
                if (is_addr_exc(bus.exc_code_i)) begin
                    badvaddr_d = bus.exc_badva_i;
                end
            end
            CMT_ERET: begin
                status_d[STATUS_EXL] = 1'b0;
            end
            CMT_MTC0: begin
                case (bus.waddr_i)
                    CP0_REG_STATUS: status_d = {STATUS_CU, bus.data_i[27:0]};
                    CP0_REG_CAUSE:  cause_d  = (cause_d & ~CAUSE_SW_MASK) | (bus.data_i & CAUSE_SW_MASK);
                    CP0_REG_EPC:    epc_d    = bus.data_i;
                    default:        ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (!rst) begin
            case (bus.raddr_i)
                CP0_REG_BADVADDR: rdata = badvaddr_q;
                CP0_REG_COUNT:    rdata = count;
                CP0_REG_COMPARE:  rdata = compare;
                CP0_REG_STATUS:   rdata = status_q;
                CP0_REG_CAUSE:    rdata = cause_q;
                CP0_REG_EPC:      rdata = epc_q;
                CP0_REG_PRID:     rdata = PRID_VAL;
                CP0_REG_CONFIG:   rdata = CONFIG_VAL;
                default:          rdata = 32'd0;
            endcase
        end
    end

    assign bus.data_o        = rdata;
    assign bus.status_o      = status_q;
    assign bus.cause_o       = cause_q;
    assign bus.epc_o         = epc_q;
    assign bus.timer_int_o   = timer_int;
    assign bus.int_pending_o = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                             & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_exc_regs.sv
// Directed and randomised bench for cp0_exc_regs; expectations are queued at drive time
// and drained against the DUT at the next negedge.
module tb_cp0_exc_regs;

    localparam int          NUM_HW_INT = 6;
    localparam int          COUNT_DIV  = 1;
    localparam logic [31:0] PRID_VAL   = 32'h004C_0102;
    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

    localparam int OBS_TIMER   = 100;
    localparam int OBS_PENDING = 101;
    localparam int OBS_STATUS  = 102;
    localparam int OBS_CAUSE   = 103;
    localparam int OBS_EPC     = 104;
    localparam int OBS_CAUSE_IP = 105;

    logic clk;
    logic rst;

    cp0_exc_regs_if #(.NUM_HW_INT(NUM_HW_INT)) bus ();

    cp0_exc_regs #(
        .NUM_HW_INT (NUM_HW_INT),
        .COUNT_DIV  (COUNT_DIV),
        .PRID_VAL   (PRID_VAL),
        .CONFIG_VAL (CONFIG_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_obs(input string tag, input int sel, input logic [31:0] val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    task automatic read_obs(input int sel, output logic [31:0] v);
        if (sel < 32) begin
            bus.raddr_i = sel[4:0];
            #1;
            v = bus.data_o;
        end else begin
            case (sel)
                OBS_TIMER:    v = {31'd0, bus.timer_int_o};
                OBS_PENDING:  v = {31'd0, bus.int_pending_o};
                OBS_STATUS:   v = bus.status_o;
                OBS_CAUSE:    v = bus.cause_o;
                OBS_EPC:      v = bus.epc_o;
                OBS_CAUSE_IP: v = {26'd0, bus.cause_o[15:10]};
                default:      v = 32'hX;
            endcase
        end
    endtask

    task automatic drain();
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            read_obs(sel_q.pop_front(), got);
            check_val(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    // driver tasks (called just after a negedge)
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.we_i    = 1'b1;
        bus.waddr_i = addr;
        bus.data_i  = data;
        cycle();
        bus.we_i    = 1'b0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                             input logic in_delay, input logic [31:0] badva);
        bus.exc_valid_i    = 1'b1;
        bus.exc_code_i     = code;
        bus.exc_pc_i       = pc;
        bus.exc_in_delay_i = in_delay;
        bus.exc_badva_i    = badva;
        cycle();
        bus.exc_valid_i    = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [5:0]  rnd_int;
        int          waited;

        rst = 1'b1;
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.raddr_i = '0; bus.data_i = '0;
        bus.int_i = '0; bus.exc_valid_i = 1'b0; bus.exc_code_i = '0; bus.exc_pc_i = '0;
        bus.exc_in_delay_i = 1'b0; bus.exc_badva_i = '0; bus.eret_i = 1'b0;
        @(negedge clk);
        cycle();

        // reset state; reads are forced to 0 while rst is high
        expect_obs("rst_status",  OBS_STATUS, 32'h1000_0000);
        expect_obs("rst_cause",   OBS_CAUSE,  32'd0);
        expect_obs("rst_epc",     OBS_EPC,    32'd0);
        expect_obs("rst_timer",   OBS_TIMER,  32'd0);
        expect_obs("rst_rd_prid", 15,         32'd0);
        drain();

        // 1: count after five cycles
        rst = 1'b0;
        repeat (5) cycle();
        expect_obs("t1_count",  9,          (COUNT_DIV == 1) ? 32'd5 : 32'd2);
        expect_obs("t1_status", 12,         32'h1000_0000);
        expect_obs("t1_prid",   15,         PRID_VAL);
        expect_obs("t1_config", 16,         CONFIG_VAL);
        expect_obs("t1_badva",  8,          32'd0);
        expect_obs("t1_unused", 3,          32'd0);
        drain();

        // 2: timer match and clear
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        expect_obs("t2_count_wr", 9,         32'd10);
        expect_obs("t2_compare",  11,        32'd20);
        drain();
        repeat (10) cycle();
        expect_obs("t2_count_20", 9,         32'd20);
        expect_obs("t2_no_timer", OBS_TIMER, 32'd0);
        drain();
        cycle();
        expect_obs("t2_timer_set", OBS_TIMER, 32'd1);
        drain();
        cycle();
        expect_obs("t2_cause_ip7", OBS_CAUSE, 32'h0000_8000);
        drain();
        mtc0(5'd11, 32'd0);
        expect_obs("t2_timer_clr", OBS_TIMER, 32'd0);
        drain();
        cycle();
        expect_obs("t2_cause_clr", OBS_CAUSE, 32'd0);
        drain();

        // randomised EPC writes and interrupt line sampling
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            rnd_int = 6'($urandom_range(0, 63));
            bus.int_i = rnd_int;
            mtc0(5'd14, rnd);
            expect_obs("rnd_epc",      14,           rnd);
            expect_obs("rnd_cause_ip", OBS_CAUSE_IP, {26'd0, rnd_int});
            drain();
        end

        // 3: interrupt gating and first exception in a delay slot
        bus.int_i = 6'b000001;
        mtc0(5'd12, 32'h1000_FF01);
        expect_obs("t3_pending", OBS_PENDING, 32'd1);
        expect_obs("t3_status",  OBS_STATUS,  32'h1000_FF01);
        drain();
        raise_exc(5'd0, 32'h0000_0100, 1'b1, 32'd0);
        expect_obs("t3_epc",        OBS_EPC,     32'h0000_00FC);
        expect_obs("t3_cause",      OBS_CAUSE,   32'h8000_0400);
        expect_obs("t3_status_exl", OBS_STATUS,  32'h1000_FF03);
        expect_obs("t3_pending_lo", OBS_PENDING, 32'd0);
        drain();

        // 4: nested exception keeps EPC/BD, records AdES address; ERET clears EXL
        raise_exc(5'd5, 32'h0000_0200, 1'b0, 32'h1234_5671);
        expect_obs("t4_epc",   OBS_EPC,   32'h0000_00FC);
        expect_obs("t4_cause", OBS_CAUSE, 32'h8000_0414);
        expect_obs("t4_badva", 8,         32'h1234_5671);
        drain();
        bus.eret_i = 1'b1;
        cycle();
        bus.eret_i = 1'b0;
        expect_obs("t4_eret_status", OBS_STATUS,  32'h1000_FF01);
        expect_obs("t4_eret_pending", OBS_PENDING, 32'd1);
        drain();

        // 5: exception, ERET and MTC0 EPC in one cycle
        bus.eret_i = 1'b1;
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hDEAD_BEEF;
        raise_exc(5'd4, 32'h0000_0300, 1'b0, 32'hAAAA_0000);
        bus.eret_i = 1'b0; bus.we_i = 1'b0;
        expect_obs("t5_epc",    OBS_EPC,    32'h0000_0300);
        expect_obs("t5_status", OBS_STATUS, 32'h1000_FF03);
        expect_obs("t5_cause",  OBS_CAUSE,  32'h0000_0410);
        expect_obs("t5_badva",  8,          32'hAAAA_0000);
        drain();
        mtc0(5'd8, 32'h5555_5555);
        mtc0(5'd15, 32'h5555_5555);
        expect_obs("t5_badva_ro", 8,  32'hAAAA_0000);
        expect_obs("t5_prid_ro",  15, PRID_VAL);
        drain();
        mtc0(5'd12, 32'hF000_0001);
        expect_obs("t5_status_cu", OBS_STATUS, 32'h1000_0001);
        drain();
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_obs("t5_cause_mask", OBS_CAUSE,   32'h00C0_0710);
        expect_obs("t5_pending_im", OBS_PENDING, 32'd0);
        drain();
        mtc0(5'd12, 32'h1000_0301);
        expect_obs("t5_sw_pending", OBS_PENDING, 32'd1);
        drain();

        // 6: Count wrap, then reset mid-count with the timer flag set
        mtc0(5'd9, 32'hFFFF_FFFF);
        expect_obs("t6_count_max", 9, 32'hFFFF_FFFF);
        drain();
        cycle();
        expect_obs("t6_count_wrap", 9, 32'd0);
        drain();
        mtc0(5'd11, 32'd5);
        waited = 0;
        while (bus.timer_int_o !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        expect_obs("t6_timer_before_rst", OBS_TIMER, 32'd1);
        drain();
        rst = 1'b1;
        cycle();
        expect_obs("t6_rst_timer",  OBS_TIMER,  32'd0);
        expect_obs("t6_rst_status", OBS_STATUS, 32'h1000_0000);
        expect_obs("t6_rst_epc",    OBS_EPC,    32'd0);
        expect_obs("t6_rst_read",   9,          32'd0);
        drain();
        rst = 1'b0;
        cycle();
        expect_obs("t6_count_after_rst", 9, 32'd1);
        drain();

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
